sigmag_packer: RTL and testbench

Consumer end of the sign/magnitude quantizer stream in the DSP chain. Takes the 2-bit {mag,sig} samples produced after DC compensation and quantization, packs them into fixed-width words, buffers the words in a small FIFO toward a valid/ready sink (DMA or CPU bridge), and keeps running sig/mag occupancy statistics used to check the quantizer threshold loop (target mag ≈ 30 %).

---
 rtl/sigmag_packer_pkg.sv | 10 +
 rtl/sigmag_packer_fifo.sv | 57 +++++
 rtl/sigmag_packer.sv | 151 +++++++++++++++
 tb/tb_sigmag_packer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sigmag_packer_pkg.sv
// Shared DSP constants for the sign/magnitude quantizer stream.
// Sample layout is {mag,sig}; the percentage scale feeds the occupancy statistics.
package sigmag_packer_pkg;
  localparam int SIGMAG_W = 2;
  localparam int SIG_BIT  = 0;
  localparam int MAG_BIT  = 1;

  localparam int         PCT_W     = 7;
  localparam logic [6:0] PCT_SCALE = 7'd100;
endpackage

// File: rtl/sigmag_packer_fifo.sv
// Synchronous word FIFO with a registered storage read port and push-accept feedback.
// clr empties the FIFO synchronously without touching the storage contents.
module sync_fifo_w #(
  parameter int W       = 32,
  parameter int DEPTH_N = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_ok,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << DEPTH_N;

  logic [W-1:0]       mem [DEPTH];
  logic [DEPTH_N-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_N:0]   count;
  logic               pop;

  assign full     = (count == (DEPTH_N+1)'(DEPTH));
  assign empty    = (count == '0);
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr];
  assign pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so push at full is still accepted.
  assign push_ok  = push && (!full || pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sigmag_packer.sv
// Packs {mag,sig} samples into 2*PACK_N-bit words, buffers them toward a sink,
// and reports sig/mag occupancy percentages once per 2^STAT_N valid samples.
module sigmag_packer
  import sigmag_packer_pkg::*;
#(
  parameter int PACK_N       = 16,
  parameter int FIFO_DEPTH_N = 2,
  parameter int STAT_N       = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     en,
  input  logic                     sig,
  input  logic                     mag,
  input  logic                     valid_in,
  output logic [SIGMAG_W*PACK_N-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [PCT_W-1:0]         sig_pct,
  output logic [PCT_W-1:0]         mag_pct,
  output logic                     stat_lch
);
  localparam int WORD_W = SIGMAG_W * PACK_N;
  localparam int POS_W  = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam int PROD_W = STAT_N + 8;

  // Output handshake: a word transfers on every cycle where m_valid && m_ready;
  // m_data holds steady while m_valid is high and m_ready is low.

  logic [POS_W-1:0]    pos_q;
  logic [WORD_W-1:0]   word_q, word_nxt, push_data_q;
  logic                push_q, push_ok, drop, last_pos;
  logic [SIGMAG_W-1:0] smp;
  logic                fifo_full, fifo_empty, unused_fifo_flags;

  always_comb begin
    smp          = '0;
    smp[SIG_BIT] = sig;
    smp[MAG_BIT] = mag;
  end

  assign last_pos = (pos_q == POS_W'(PACK_N - 1));

  always_comb begin
    word_nxt = word_q;
    word_nxt[pos_q*SIGMAG_W +: SIGMAG_W] = smp;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else if (!en) begin
      pos_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (valid_in) begin
        if (last_pos) begin
          pos_q       <= '0;
          word_q      <= '0;
          push_q      <= 1'b1;
          push_data_q <= word_nxt;
        end else begin
          pos_q  <= pos_q + 1'b1;
          word_q <= word_nxt;
        end
      end
    end
  end

  sync_fifo_w #(.W(WORD_W), .DEPTH_N(FIFO_DEPTH_N)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (!en),
    .push      (push_q),
    .push_data (push_data_q),
    .push_ok   (push_ok),
    .rd_data   (m_data),
    .rd_valid  (m_valid),
    .rd_ready  (m_ready),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_fifo_flags = &{1'b0, fifo_full, fifo_empty};

  assign drop = push_q && !push_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (!en) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  logic [STAT_N-1:0] smp_cnt_q;
  logic [STAT_N:0]   sig_cnt_q, mag_cnt_q, sig_tot, mag_tot;
  logic [PROD_W-1:0] sig_prod, mag_prod;
  logic              period_end;

  // Totals include the current sample so the closing sample is counted.
  assign sig_tot    = sig_cnt_q + {{STAT_N{1'b0}}, sig};
  assign mag_tot    = mag_cnt_q + {{STAT_N{1'b0}}, mag};
  assign sig_prod   = PROD_W'(sig_tot) * PROD_W'(PCT_SCALE);
  assign mag_prod   = PROD_W'(mag_tot) * PROD_W'(PCT_SCALE);
  assign period_end = (smp_cnt_q == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      smp_cnt_q <= '0;
      sig_cnt_q <= '0;
      mag_cnt_q <= '0;
      sig_pct   <= '0;
      mag_pct   <= '0;
      stat_lch  <= 1'b0;
    end else if (!en) begin
      smp_cnt_q <= '0;
      sig_cnt_q <= '0;
      mag_cnt_q <= '0;
      stat_lch  <= 1'b0;
    end else begin
      stat_lch <= 1'b0;
      if (valid_in) begin
        if (period_end) begin
          smp_cnt_q <= '0;
          sig_cnt_q <= '0;
          mag_cnt_q <= '0;
          sig_pct   <= sig_prod[STAT_N +: PCT_W];
          mag_pct   <= mag_prod[STAT_N +: PCT_W];
          stat_lch  <= 1'b1;
        end else begin
          smp_cnt_q <= smp_cnt_q + 1'b1;
          sig_cnt_q <= sig_tot;
          mag_cnt_q <= mag_tot;
        end
      end
    end
  end
endmodule

// File: tb/tb_sigmag_packer.sv
// Directed bench for sigmag_packer: packing, sparse input, backpressure, full boundary,
// statistics, reset and enable flush, all with hand-computed expected words.
module tb_sigmag_packer;
  localparam int PACK_N       = 16;
  localparam int FIFO_DEPTH_N = 2;
  localparam int STAT_N       = 4;
  localparam int W            = 2 * PACK_N;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         en = 1'b0;
  logic         sig = 1'b0;
  logic         mag = 1'b0;
  logic         valid_in = 1'b0;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         overflow;
  logic [15:0]  drop_cnt;
  logic [6:0]   sig_pct, mag_pct;
  logic         stat_lch;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  sigmag_packer #(.PACK_N(PACK_N), .FIFO_DEPTH_N(FIFO_DEPTH_N), .STAT_N(STAT_N)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .sig      (sig),
    .mag      (mag),
    .valid_in (valid_in),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .sig_pct  (sig_pct),
    .mag_pct  (mag_pct),
    .stat_lch (stat_lch)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic put(input logic [1:0] s);
    mag = s[1];
    sig = s[0];
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit keep);
    for (int k = 0; k < PACK_N; k++) put(w[2*k +: 2]);
    if (keep) exp_q.push_back(w);
  endtask

  task automatic pop_word(input string tag);
    int waited;
    logic [W-1:0] e;
    waited = 0;
    while (!m_valid && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (m_valid) begin
      chk(tag, m_data, e);
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
  endtask

  initial begin
    // reset
    en = 1'b1;
    #12;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("rst_sig_pct", {25'd0, sig_pct}, 32'd0);
    chk("rst_mag_pct", {25'd0, mag_pct}, 32'd0);
    chk("rst_stat_lch", {31'd0, stat_lch}, 32'd0);
    resetn = 1'b1;
    idle(1);

    // dense packing, k%4
    for (int k = 0; k < 15; k++) put(2'(k % 4));
    chk("dense_no_early", {31'd0, m_valid}, 32'd0);
    put(2'd3);
    chk("dense_latency_lo", {31'd0, m_valid}, 32'd0);
    chk("dense_stat_lch", {31'd0, stat_lch}, 32'd1);
    chk("dense_sig_pct", {25'd0, sig_pct}, 32'd50);
    chk("dense_mag_pct", {25'd0, mag_pct}, 32'd50);
    idle(1);
    chk("dense_latency_hi", {31'd0, m_valid}, 32'd1);
    chk("dense_stat_lch_off", {31'd0, stat_lch}, 32'd0);
    exp_q.push_back(32'hE4E4E4E4);
    pop_word("dense_word");

    // all sig=1, mag=0
    for (int k = 0; k < PACK_N; k++) put(2'b01);
    exp_q.push_back(32'h55555555);
    chk("sig_only_sig_pct", {25'd0, sig_pct}, 32'd100);
    chk("sig_only_mag_pct", {25'd0, mag_pct}, 32'd0);
    pop_word("sig_only_word");

    // sparse: valid every third cycle
    for (int k = 0; k < PACK_N; k++) begin
      put(2'(k % 4));
      if (k == 14) chk("sparse_no_early", {31'd0, m_valid}, 32'd0);
      if (k < PACK_N - 1) idle(2);
    end
    exp_q.push_back(32'hE4E4E4E4);
    pop_word("sparse_word");

    // statistics: 5 mag, 8 sig
    for (int k = 0; k < 5; k++) put(2'b11);
    for (int k = 0; k < 3; k++) put(2'b01);
    for (int k = 0; k < 8; k++) put(2'b00);
    chk("stat_lch_pulse", {31'd0, stat_lch}, 32'd1);
    chk("stat_sig_pct", {25'd0, sig_pct}, 32'd50);
    chk("stat_mag_pct", {25'd0, mag_pct}, 32'd31);
    idle(1);
    chk("stat_lch_single", {31'd0, stat_lch}, 32'd0);
    exp_q.push_back(32'h000057FF);
    pop_word("stat_word");
    for (int k = 0; k < PACK_N; k++) put(2'b11);
    chk("ones_sig_pct", {25'd0, sig_pct}, 32'd100);
    chk("ones_mag_pct", {25'd0, mag_pct}, 32'd100);
    exp_q.push_back(32'hFFFFFFFF);
    pop_word("ones_word");

    // backpressure: 5 words into a 4-deep FIFO
    send_word(32'hE4E4E4E4, 1'b1);
    send_word(32'h39393939, 1'b1);
    send_word(32'h4E4E4E4E, 1'b1);
    send_word(32'h93939393, 1'b1);
    send_word(32'hAAAAAAAA, 1'b0);
    idle(2);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    for (int i = 0; i < 4; i++) pop_word($sformatf("bp_word%0d", i + 1));
    idle(2);
    chk("bp_drained", {31'd0, m_valid}, 32'd0);

    // flush clears drop state, holds percentages (last period: all mag)
    en = 1'b0;
    idle(1);
    en = 1'b1;
    chk("flush_overflow", {31'd0, overflow}, 32'd0);
    chk("flush_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("flush_sig_hold", {25'd0, sig_pct}, 32'd0);
    chk("flush_mag_hold", {25'd0, mag_pct}, 32'd100);

    // full boundary: pop and push in the same cycle
    send_word(32'h12345678, 1'b1);
    send_word(32'h9ABCDEF0, 1'b1);
    send_word(32'h0F0F0F0F, 1'b1);
    send_word(32'hC3C3C3C3, 1'b1);
    send_word(32'h76543210, 1'b1);
    chk("full_head", m_data, exp_q.pop_front());
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    idle(1);
    chk("full_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("full_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) pop_word($sformatf("full_word%0d", i + 2));

    // reset mid-word
    for (int k = 0; k < 7; k++) put(2'b10);
    resetn = 1'b0;
    #2;
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_m_data", m_data, 32'd0);
    chk("mid_rst_sig_pct", {25'd0, sig_pct}, 32'd0);
    chk("mid_rst_mag_pct", {25'd0, mag_pct}, 32'd0);
    resetn = 1'b1;
    idle(1);
    send_word(32'h93939393, 1'b1);
    chk("post_rst_sig_pct", {25'd0, sig_pct}, 32'd50);
    chk("post_rst_mag_pct", {25'd0, mag_pct}, 32'd50);
    pop_word("post_rst_word");

    // en low mid-word with a buffered word
    send_word(32'h39393939, 1'b1);
    for (int k = 0; k < 5; k++) put(2'b11);
    en = 1'b0;
    mag = 1'b1;
    sig = 1'b1;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    en = 1'b1;
    exp_q.delete();
    chk("en_flush_m_valid", {31'd0, m_valid}, 32'd0);
    chk("en_flush_sig_hold", {25'd0, sig_pct}, 32'd50);
    chk("en_flush_mag_hold", {25'd0, mag_pct}, 32'd50);
    send_word(32'h55555555, 1'b1);
    chk("en_flush_stat_sig", {25'd0, sig_pct}, 32'd100);
    chk("en_flush_stat_mag", {25'd0, mag_pct}, 32'd0);
    pop_word("en_flush_word");

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
